// File: rtl/io_ctrl_pkg.sv
// Shared register offsets, status/IRQ bit positions and TX state type for io_ctrl.
package io_ctrl_pkg;

  localparam logic [5:0] IO_OFS_LEDR_LO   = 6'h00;
  localparam logic [5:0] IO_OFS_LEDR_HI   = 6'h01;
  localparam logic [5:0] IO_OFS_LEDG      = 6'h02;
  localparam logic [5:0] IO_OFS_SW_LO     = 6'h03;
  localparam logic [5:0] IO_OFS_SW_HI     = 6'h04;
  localparam logic [5:0] IO_OFS_KEY       = 6'h05;
  localparam logic [5:0] IO_OFS_KEY_EDGE  = 6'h06;
  localparam logic [5:0] IO_OFS_IRQ_EN    = 6'h07;
  localparam logic [5:0] IO_OFS_UART_DATA = 6'h08;
  localparam logic [5:0] IO_OFS_UART_STAT = 6'h09;
  localparam logic [5:0] IO_OFS_UART_CTL  = 6'h0A;
  localparam logic [5:0] IO_OFS_SEG       = 6'h10;

  localparam int unsigned STAT_RX_NONEMPTY = 0;
  localparam int unsigned STAT_RX_FULL     = 1;
  localparam int unsigned STAT_TX_EMPTY    = 2;
  localparam int unsigned STAT_TX_FULL     = 3;
  localparam int unsigned STAT_RX_OVF      = 4;
  localparam int unsigned STAT_TX_OVF      = 5;
  localparam int unsigned STAT_TX_BUSY     = 6;

  localparam int unsigned IRQ_KEY = 0;
  localparam int unsigned IRQ_RX  = 1;
  localparam int unsigned IRQ_TX  = 2;
  localparam int unsigned IRQ_OVF = 3;

  localparam int unsigned CTL_CLR_RX_OVF = 0;
  localparam int unsigned CTL_CLR_TX_OVF = 1;
  localparam int unsigned CTL_FLUSH      = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT
  } tx_state_e;

endpackage

// File: rtl/io_ctrl_fifo.sv
// Small synchronous FIFO with extra-bit wrap pointers; flush empties it and wins over push.
module io_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped I/O block: LEDs, switches, keys, 7-seg digits and a FIFO-buffered UART with IRQ.
// The read data port is named dout because "do" is a reserved word.
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int unsigned LEDR_W     = 10,
  parameter int unsigned SW_W       = 10,
  parameter int unsigned KEY_W      = 4,
  parameter int unsigned NUM_SEG    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          addr,
  input  logic                 we,
  input  logic                 re,
  input  logic [7:0]           di,
  output logic [7:0]           dout,
  input  logic [SW_W-1:0]      switches,
  input  logic [KEY_W-1:0]     keys,
  output logic [LEDR_W-1:0]    ledr,
  output logic [7:0]           ledg,
  output logic [7*NUM_SEG-1:0] seg,
  input  logic [7:0]           uart_rxd_data,
  input  logic                 uart_rxd_done,
  output logic [7:0]           uart_txd_data,
  output logic                 uart_transmit,
  input  logic                 uart_txd_done,
  output logic                 irq
);

  localparam logic [15:0] LEDR_MASK = 16'((32'd1 << LEDR_W) - 32'd1);

  logic [5:0]       ofs;
  logic             sel, wr, rd;
  logic [15:0]      ledr_q;
  logic [7:0]       ledg_q;
  logic [6:0]       seg_q [NUM_SEG];
  logic [3:0]       irq_en;
  logic [KEY_W-1:0] key_s1, key_s2, key_prev, key_edge, key_clr;
  logic             rx_ovf, tx_ovf, irq_q;
  logic [7:0]       dout_q, rdata, stat, txd_q;
  logic             transmit_q;
  tx_state_e        state;

  logic             rx_pop, rx_full, rx_empty, tx_push, tx_pop, tx_full, tx_empty;
  logic             ctl_wr, flush, rx_ovf_set, tx_ovf_set, irq_next;
  logic [7:0]       rx_head, tx_head;
  logic [15:0]      sw_ext;

  assign ofs    = addr[5:0];
  assign sel    = (addr[15:6] == BASE_ADDR[15:6]);
  assign wr     = we && sel;
  assign rd     = re && sel;
  assign sw_ext = 16'(switches);

  assign ctl_wr     = wr && (ofs == IO_OFS_UART_CTL);
  assign flush      = ctl_wr && di[CTL_FLUSH];
  assign rx_pop     = rd && (ofs == IO_OFS_UART_DATA);
  assign tx_push    = wr && (ofs == IO_OFS_UART_DATA);
  assign tx_pop     = (state == TX_START);
  assign rx_ovf_set = uart_rxd_done && rx_full && !rx_pop && !flush;
  assign tx_ovf_set = tx_push && tx_full && !tx_pop;
  assign key_clr    = (wr && (ofs == IO_OFS_KEY_EDGE)) ? di[KEY_W-1:0] : '0;

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_rxd_done),
    .pop   (rx_pop),
    .flush (flush),
    .din   (uart_rxd_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (di),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    stat                   = '0;
    stat[STAT_RX_NONEMPTY] = !rx_empty;
    stat[STAT_RX_FULL]     = rx_full;
    stat[STAT_TX_EMPTY]    = tx_empty;
    stat[STAT_TX_FULL]     = tx_full;
    stat[STAT_RX_OVF]      = rx_ovf;
    stat[STAT_TX_OVF]      = tx_ovf;
    stat[STAT_TX_BUSY]     = (state != TX_IDLE);
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      IO_OFS_LEDR_LO:   rdata = ledr_q[7:0];
      IO_OFS_LEDR_HI:   rdata = ledr_q[15:8];
      IO_OFS_LEDG:      rdata = ledg_q;
      IO_OFS_SW_LO:     rdata = sw_ext[7:0];
      IO_OFS_SW_HI:     rdata = sw_ext[15:8];
      IO_OFS_KEY:       rdata = 8'(key_s2);
      IO_OFS_KEY_EDGE:  rdata = 8'(key_edge);
      IO_OFS_IRQ_EN:    rdata = {4'b0000, irq_en};
      IO_OFS_UART_DATA: rdata = rx_empty ? '0 : rx_head;
      IO_OFS_UART_STAT: rdata = stat;
      default:          ;
    endcase
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      if (ofs == 6'(IO_OFS_SEG + i)) rdata = {1'b0, seg_q[i]};
    end
  end

  always_comb begin
    irq_next = (|(key_edge & {KEY_W{irq_en[IRQ_KEY]}}))
             | (!rx_empty & irq_en[IRQ_RX])
             | (tx_empty & irq_en[IRQ_TX])
             | ((rx_ovf | tx_ovf) & irq_en[IRQ_OVF]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ledr_q   <= 16'h00AA & LEDR_MASK;
      ledg_q   <= 8'hAA;
      irq_en   <= '0;
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
      key_edge <= '0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
      irq_q    <= 1'b0;
      dout_q   <= '0;
      for (int unsigned i = 0; i < NUM_SEG; i++) seg_q[i] <= 7'h7F;
    end else begin
      if (wr) begin
        case (ofs)
          IO_OFS_LEDR_LO: ledr_q <= {ledr_q[15:8], di} & LEDR_MASK;
          IO_OFS_LEDR_HI: ledr_q <= {di, ledr_q[7:0]} & LEDR_MASK;
          IO_OFS_LEDG:    ledg_q <= di;
          IO_OFS_IRQ_EN:  irq_en <= di[3:0];
          default:        ;
        endcase
        for (int unsigned i = 0; i < NUM_SEG; i++) begin
          if (ofs == 6'(IO_OFS_SEG + i)) seg_q[i] <= di[6:0];
        end
      end
      key_s1   <= ~keys;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      // New press edges are OR'd in after the W1C mask so a same-cycle set survives.
      key_edge <= (key_edge & ~key_clr) | (key_s2 & ~key_prev);
      rx_ovf   <= (rx_ovf & !(ctl_wr && di[CTL_CLR_RX_OVF])) | rx_ovf_set;
      tx_ovf   <= (tx_ovf & !(ctl_wr && di[CTL_CLR_TX_OVF])) | tx_ovf_set;
      irq_q    <= irq_next;
      if (re) dout_q <= sel ? rdata : '0;
    end
  end

  // START re-checks emptiness: a flush in the IDLE->START cycle must not send a stale head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TX_IDLE;
      txd_q      <= '0;
      transmit_q <= 1'b0;
    end else begin
      transmit_q <= 1'b0;
      case (state)
        TX_IDLE:  if (!tx_empty) state <= TX_START;
        TX_START: begin
          if (!tx_empty) begin
            txd_q      <= tx_head;
            transmit_q <= 1'b1;
            state      <= TX_WAIT;
          end else begin
            state <= TX_IDLE;
          end
        end
        TX_WAIT:  if (uart_txd_done) state <= TX_IDLE;
        default:  state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < NUM_SEG; i++) seg[7*i +: 7] = seg_q[i];
  end

  assign ledr          = ledr_q[LEDR_W-1:0];
  assign ledg          = ledg_q;
  assign dout          = dout_q;
  assign uart_txd_data = txd_q;
  assign uart_transmit = transmit_q;
  assign irq           = irq_q;

endmodule
